// File: rtl/uart_row_loader_pkg.sv
// rtl/uart_row_loader_pkg.sv - shared parser states, command byte and parameter defaults for the UART row loader
package uart_row_loader_pkg;

  // 16 MHz clk_in / 246154 baud
  localparam int DEF_UART_TICKS_PER_BIT      = 65;
  localparam int DEF_UART_TICKS_PER_BIT_SIZE = 7;
  localparam int DEF_PIXELS_PER_ROW          = 64;
  localparam int DEF_ROW_COUNT               = 32;

  // RAM address layout is {row[4:0], col[5:0]}
  localparam int ROW_W = 5;
  localparam int COL_W = 6;

  // Opens a row command; inside a row it is ordinary pixel data
  localparam logic [7:0] CMD_ROW = 8'h4C;

  // Silent-line limit for an open row, in bit-times
  localparam int TIMEOUT_BIT_TIMES = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROW    = 2'd1,
    ST_PIX_HI = 2'd2,
    ST_PIX_LO = 2'd3
  } parser_state_t;

endpackage

// File: rtl/uart_row_loader_byte_rx.sv
// rtl/uart_row_loader_byte_rx.sv - uart_byte_rx: synchronizer, tick counter and 8N1 shifter with byte_valid/framing_error
module uart_byte_rx
  import uart_row_loader_pkg::*;
#(
  parameter int UART_TICKS_PER_BIT      = DEF_UART_TICKS_PER_BIT,
  parameter int UART_TICKS_PER_BIT_SIZE = DEF_UART_TICKS_PER_BIT_SIZE
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_error,
  output logic       rx_active
);

  localparam int TW = UART_TICKS_PER_BIT_SIZE;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  localparam logic [TW-1:0] TICK_LAST      = TW'(UART_TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF_LAST = TW'(UART_TICKS_PER_BIT / 2 - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          framing_error_q, framing_error_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Bit-level receive: verify start at mid-bit, then sample data and stop one bit-time apart
  always_comb begin
    state_d         = state_q;
    tick_d          = tick_q;
    bit_d           = bit_q;
    shift_d         = shift_q;
    byte_valid_d    = 1'b0;
    framing_error_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
          tick_d  = '0;
        end
      end
      RX_START: begin
        if (tick_q == TICK_HALF_LAST) begin
          tick_d  = '0;
          bit_d   = '0;
          // A line that is high again at mid-start was a glitch
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = RX_WAIT_HIGH;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        // A low stop bit could be mid-break; re-arm only once the line idles high
        if (rx_sync_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q         <= RX_IDLE;
      tick_q          <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      byte_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_q          <= tick_d;
      bit_q           <= bit_d;
      shift_q         <= shift_d;
      byte_valid_q    <= byte_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign byte_data     = shift_q;
  assign byte_valid    = byte_valid_q;
  assign framing_error = framing_error_q;
  assign rx_active     = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_row_loader.sv
// rtl/uart_row_loader.sv - row-command parser writing 16-bit pixels to RAM; UART_ROW_LOADER_TIMEOUT_EN adds a stalled-row timeout
module uart_row_loader
  import uart_row_loader_pkg::*;
#(
  parameter int UART_TICKS_PER_BIT      = DEF_UART_TICKS_PER_BIT,
  parameter int UART_TICKS_PER_BIT_SIZE = DEF_UART_TICKS_PER_BIT_SIZE,
  parameter int PIXELS_PER_ROW          = DEF_PIXELS_PER_ROW,
  parameter int ROW_COUNT               = DEF_ROW_COUNT
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [10:0] ram_write_addr,
  output logic [15:0] ram_write_data,
  output logic        ram_write_enable,
  output logic        row_done,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIXELS_PER_ROW - 1);

  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_framing_error;
  logic       rx_active;
  logic       timeout_hit;

  parser_state_t    state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       hi_q, hi_d;
  logic [10:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic             we_q, we_d;
  logic             row_done_q, row_done_d;
  logic             frame_error_q, frame_error_d;

  uart_byte_rx #(
    .UART_TICKS_PER_BIT      (UART_TICKS_PER_BIT),
    .UART_TICKS_PER_BIT_SIZE (UART_TICKS_PER_BIT_SIZE)
  ) u_byte_rx (
    .clk_in        (clk_in),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .byte_data     (rx_byte),
    .byte_valid    (rx_byte_valid),
    .framing_error (rx_framing_error),
    .rx_active     (rx_active)
  );

`ifdef UART_ROW_LOADER_TIMEOUT_EN
  localparam int TIMEOUT_TICKS = TIMEOUT_BIT_TIMES * UART_TICKS_PER_BIT;
  localparam int TIMEOUT_W     = $clog2(TIMEOUT_TICKS);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_TICKS - 1);

  logic [TIMEOUT_W-1:0] idle_ticks_q, idle_ticks_d;

  // Count silent-line ticks while a row command is open; any reception restarts the count
  always_comb begin
    idle_ticks_d = idle_ticks_q;
    timeout_hit  = 1'b0;
    if (state_q == ST_IDLE || rx_active) begin
      idle_ticks_d = '0;
    end else if (idle_ticks_q == TIMEOUT_LAST) begin
      idle_ticks_d = '0;
      timeout_hit  = 1'b1;
    end else begin
      idle_ticks_d = idle_ticks_q + 1'b1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      idle_ticks_q <= '0;
    end else begin
      idle_ticks_q <= idle_ticks_d;
    end
  end
`else
  logic unused_rx_active;
  assign unused_rx_active = rx_active;
  assign timeout_hit      = 1'b0;
`endif

  // Byte-level parser: 'L', row index, then hi/lo byte pairs until the row is full
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    hi_d          = hi_q;
    addr_d        = addr_q;
    data_d        = data_q;
    we_d          = 1'b0;
    row_done_d    = 1'b0;
    frame_error_d = 1'b0;
    if (rx_framing_error || timeout_hit) begin
      // Abort whatever was open; already-written pixels stay in RAM
      frame_error_d = 1'b1;
      state_d       = ST_IDLE;
    end else if (rx_byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == CMD_ROW) begin
            state_d = ST_ROW;
          end
        end
        ST_ROW: begin
          if (int'(rx_byte) < ROW_COUNT) begin
            row_d   = rx_byte[ROW_W-1:0];
            col_d   = '0;
            state_d = ST_PIX_HI;
          end else begin
            frame_error_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
        ST_PIX_HI: begin
          hi_d    = rx_byte;
          state_d = ST_PIX_LO;
        end
        ST_PIX_LO: begin
          addr_d = {row_q, col_q};
          data_d = {hi_q, rx_byte};
          we_d   = 1'b1;
          if (col_q == COL_LAST) begin
            // Row complete: never roll col over into another row
            row_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = ST_PIX_HI;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Parser and output registers; address/data hold between write strobes
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      hi_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      row_done_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      hi_q          <= hi_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      we_q          <= we_d;
      row_done_q    <= row_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign ram_write_addr   = addr_q;
  assign ram_write_data   = data_q;
  assign ram_write_enable = we_q;
  assign row_done         = row_done_q;
  assign frame_error      = frame_error_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_row_loader.sv
// tb/tb_uart_row_loader.sv - randomized byte-stream bench for uart_row_loader with a command-level reference model
`timescale 1ns/1ps
module tb_uart_row_loader;

  localparam int TPB  = 17;
  localparam int TSZ  = 5;
  localparam int PPR  = 64;
  localparam int ROWS = 32;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic [10:0] ram_write_addr;
  logic [15:0] ram_write_data;
  logic        ram_write_enable;
  logic        row_done;
  logic        frame_error;
  logic        busy;

  uart_row_loader #(
    .UART_TICKS_PER_BIT      (TPB),
    .UART_TICKS_PER_BIT_SIZE (TSZ),
    .PIXELS_PER_ROW          (PPR),
    .ROW_COUNT               (ROWS)
  ) dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .uart_rx          (uart_rx),
    .ram_write_addr   (ram_write_addr),
    .ram_write_data   (ram_write_data),
    .ram_write_enable (ram_write_enable),
    .row_done         (row_done),
    .frame_error      (frame_error),
    .busy             (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         cmp_e;
  int          m_phase;   // 0 await 'L', 1 await row, 2 await hi, 3 await lo
  int          m_row;
  int          m_col;
  logic [7:0]  m_hi;
  int          exp_fe;

  int          n_checks;
  int          n_errors;
  int          n_writes;
  int          n_fe;
  int          n_rd;
  logic [10:0] rd_addr;
  logic [10:0] last_addr;
  logic [15:0] last_data;
  logic [10:0] log_addr [0:1023];
  logic [15:0] log_data [0:1023];
  logic [15:0] shadow   [0:2047];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: what one received byte means at command level
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    wr_t w;
    if (!stop_ok) begin
      exp_fe++;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (b == 8'h4C) m_phase = 1;
        1: begin
          if (int'(b) < ROWS) begin
            m_row = int'(b);
            m_col = 0;
            m_phase = 2;
          end else begin
            exp_fe++;
            m_phase = 0;
          end
        end
        2: begin
          m_hi = b;
          m_phase = 3;
        end
        default: begin
          w.addr = 11'(m_row * PPR + m_col);
          w.data = {m_hi, b};
          w.last = (m_col == PPR - 1);
          exp_q.push_back(w);
          if (w.last) m_phase = 0;
          else begin
            m_col++;
            m_phase = 2;
          end
        end
      endcase
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk_in);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    uart_rx = 1'b0;
    tick(TPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(TPB);
    end
    uart_rx = stop_ok;
    tick(TPB);
    if (!stop_ok) begin
      uart_rx = 1'b1;
      tick(TPB);
    end
    uart_rx = 1'b1;
  endtask

  task automatic send_pixel(input logic [15:0] px);
    send_byte(px[15:8], 1'b1);
    send_byte(px[7:0], 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    uart_rx = 1'b1;
    exp_q.delete();
    m_phase = 0;
    tick(3);
    reset = 1'b0;
    tick(2 * TPB);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_fe_total"}, n_fe, exp_fe);
  endtask

  // Compare process: every write against the model, hold behaviour between writes
  always @(negedge clk_in) begin
    if (reset) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      if (ram_write_enable) begin
        log_addr[n_writes[9:0]] = ram_write_addr;
        log_data[n_writes[9:0]] = ram_write_data;
        n_writes++;
        shadow[ram_write_addr] = ram_write_data;
        if (row_done) begin
          n_rd++;
          rd_addr = ram_write_addr;
        end
        chk("pending_writes", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          cmp_e = exp_q.pop_front();
          chk("wr_addr", ram_write_addr, cmp_e.addr);
          chk("wr_data", ram_write_data, cmp_e.data);
          chk("wr_row_done", row_done, cmp_e.last);
        end
        last_addr = ram_write_addr;
        last_data = ram_write_data;
      end else begin
        chk("hold_addr", ram_write_addr, last_addr);
        chk("hold_data", ram_write_data, last_data);
        chk("row_done_without_write", row_done, 1'b0);
      end
      if (frame_error) n_fe++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bw, bf, br, cnt, k;
    logic [7:0] b;
    bit ok;
    n_checks = 0; n_errors = 0; n_writes = 0; n_fe = 0; n_rd = 0; exp_fe = 0;
    m_phase = 0; m_row = 0; m_col = 0; m_hi = '0; rd_addr = '0;

    tick(4);
    chk("rst_addr", ram_write_addr, 11'h000);
    chk("rst_data", ram_write_data, 16'h0000);
    chk("rst_we", ram_write_enable, 1'b0);
    chk("rst_row_done", row_done, 1'b0);
    chk("rst_fe", frame_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(2 * TPB);

    // Full row 4
    bw = n_writes; br = n_rd;
    send_byte(8'h4C, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int c = 0; c < PPR; c++) send_pixel(c == 3 ? 16'h9800 : 16'($urandom));
    tick(3 * TPB);
    chk("s1_writes", n_writes - bw, 64);
    chk("s1_first_addr", log_addr[bw[9:0]], 11'h100);
    chk("s1_col3", shadow[11'h103], 16'h9800);
    chk("s1_row_done_count", n_rd - br, 1);
    chk("s1_row_done_addr", rd_addr, 11'h13F);
    chk("s1_busy", busy, 1'b0);
    check_quiet("s1");

    // Row index out of range
    bw = n_writes; bf = n_fe;
    send_byte(8'h4C, 1'b1);
    send_byte(8'h20, 1'b1);
    chk("s2_busy_after_row", busy, 1'b0);
    chk("s2_fe", n_fe - bf, 1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    tick(2 * TPB);
    chk("s2_writes", n_writes - bw, 0);
    check_quiet("s2");

    // Leading junk ignored
    bw = n_writes;
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h4C, 1'b1);
    send_byte(8'h1F, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    tick(2 * TPB);
    chk("s3_writes", n_writes - bw, 2);
    chk("s3_first_addr", log_addr[bw[9:0]], 11'h7C0);
    chk("s3_first_data", log_data[bw[9:0]], 16'h1234);
    chk("s3_busy", busy, 1'b1);
    check_quiet("s3");
    do_reset();

    // Bad stop bit on pixel 10 low byte
    bw = n_writes; bf = n_fe;
    send_byte(8'h4C, 1'b1);
    send_byte(8'h07, 1'b1);
    for (int c = 0; c < 10; c++) send_pixel(16'($urandom));
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    tick(2 * TPB);
    chk("s4_writes", n_writes - bw, 10);
    chk("s4_fe", n_fe - bf, 1);
    chk("s4_busy", busy, 1'b0);
    check_quiet("s4");

    // Reset during pixel 5, then a fresh row 2
    send_byte(8'h4C, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int c = 0; c < 5; c++) send_pixel(16'($urandom) | 16'h8001);
    uart_rx = 1'b0;
    tick(TPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0];
      tick(TPB);
    end
    chk("s5_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("s5_rst_addr", ram_write_addr, 11'h000);
    chk("s5_rst_data", ram_write_data, 16'h0000);
    chk("s5_rst_we", ram_write_enable, 1'b0);
    chk("s5_rst_busy", busy, 1'b0);
    chk("s5_rst_fe", frame_error, 1'b0);
    do_reset();
    bw = n_writes; br = n_rd;
    send_byte(8'h4C, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int c = 0; c < PPR; c++) send_pixel(16'($urandom));
    tick(3 * TPB);
    chk("s5_writes", n_writes - bw, 64);
    chk("s5_first_addr", log_addr[bw[9:0]], 11'h080);
    chk("s5_row_done_addr", rd_addr, 11'h0BF);
    chk("s5_row_done_count", n_rd - br, 1);
    check_quiet("s5");

    // Randomized command streams with occasional bad stop bits
    for (int it = 0; it < 4; it++) begin
      send_byte(8'h4C, 1'b1);
      send_byte(8'($urandom_range(0, 40)), 1'b1);
      k = $urandom_range(0, 8);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) b = 8'h4C;
        ok = ($urandom_range(0, 9) != 0);
        send_byte(b, ok);
        tick($urandom_range(0, 2) * TPB);
      end
    end
    tick(3 * TPB);
    check_quiet("s6");
    do_reset();

    // Stalled row
    bf = n_fe;
    send_byte(8'h4C, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
`ifdef UART_ROW_LOADER_TIMEOUT_EN
    cnt = 0;
    while (n_fe == bf && cnt < 30 * TPB) begin
      tick(1);
      cnt++;
    end
    chk("s7_timeout_seen", n_fe - bf, 1);
    chk("s7_timeout_window", 32'(cnt >= 19 * TPB && cnt <= 21 * TPB), 32'd1);
    exp_fe++;
    m_phase = 0;
    tick(2);
    chk("s7_busy", busy, 1'b0);
`else
    cnt = 0;
    tick(30 * TPB);
    chk("s7_no_timeout", n_fe - bf, 0);
    chk("s7_busy", busy, 1'b1);
`endif
    check_quiet("s7");
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
